sar_controller: RTL
===================

# sar_controller

Successive-approximation search controller that sits directly upstream of the 4-bit magnitude comparator. It drives the comparator's B operand with a trial code and consumes the comparator's greater/lesser/equal outputs. It resolves the unknown value on the comparator's A operand one bit per cycle, MSB first. The resolved code is presented on `result` with a one-cycle `done` pulse; it is used for digitizing a threshold or a sensor code against the comparator.

## Interface
- `WIDTH`, 4: trial/result width; must match the comparator operand width (4 in the current design).

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a conversion; sampled only in IDLE.
- `greater` in 1: comparator output, A > trial.
- `lesser` in 1: comparator output, A < trial.
- `equal` in 1: comparator output, A == trial.
- `trial` out WIDTH: registered code driven to comparator B.
- `result` out WIDTH: resolved code; held until the next accepted start.
- `busy` out 1: high while a search is in progress (TEST state).
- `done` out 1: one-cycle pulse when `result` and `error` become valid.
- `error` out 1: comparator response inconsistent during the last search.

## Operation
- States: IDLE, TEST, DONE. Bit pointer `idx` runs from WIDTH-1 down to 0.
- Reset (async, any state): state=IDLE, `trial`=0, `result`=0, `busy`=0, `done`=0, `error`=0, `idx`=WIDTH-1. A search in progress is abandoned and no `done` is issued.
- IDLE: if `start`=1, go to TEST with `trial` = 1 followed by WIDTH-1 zeros (4'b1000), `idx`=WIDTH-1, `error`=0. `result` is unchanged. If `start`=0, stay.
- TEST: sample `greater`/`lesser`/`equal` each cycle. Exactly one must be high; otherwise set `error`=1, `result`=`trial`, and go to DONE.
  - `equal`: `result`=`trial`, go to DONE (early termination).
  - `greater`, idx>0: keep `trial[idx]`, set `trial[idx-1]`=1, decrement `idx`.
  - `lesser`, idx>0: clear `trial[idx]`, set `trial[idx-1]`=1, decrement `idx`.
  - `lesser`, idx=0: `result` = `trial` with bit 0 cleared, go to DONE.
  - `greater`, idx=0: unreachable with a consistent comparator. Set `error`=1, `result`=`trial`, go to DONE.
- DONE: `done`=1 for this cycle only, then go to IDLE unconditionally. `start` in DONE is ignored.
- `start` while in TEST or DONE is ignored. It is not queued.
- `trial` holds its last value in DONE and IDLE. It is reloaded only by an accepted start or cleared by reset.
- `error` holds until the next accepted start or reset.

## Timing
- Comparator path is combinational from registered `trial` to `greater`/`lesser`/`equal`, sampled at the next rising edge.
- The edge sampling `start`=1 in IDLE starts cycle 1: `busy`=1, `trial`=1000.
- Each TEST cycle resolves one bit. The number of TEST cycles is 1..WIDTH, fewer when `equal` is hit early.
- `done`, `result` and final `error` are visible in the cycle after the last TEST cycle, i.e. start-to-done = (TEST cycles + 1) edges. The worst case for WIDTH=4 is 5.
- `busy`=1 exactly in TEST cycles. `busy` and `done` are never high together.
- A new `start` is accepted at the earliest in the IDLE cycle after `done`. The back-to-back conversion period is therefore TEST cycles + 2.
- Async `rst` asserted mid-TEST: outputs clear immediately, with no dependence on the clock. After deassertion the block waits in IDLE for a new `start`.

## Test plan
All scenarios instantiate the existing comparator with the bench driving A and `trial` wired to B.
- A=8, pulse `start` -> one TEST cycle (`trial`=1000, `equal`), `done` at edge 2, `result`=1000, `error`=0.
- A=0 -> trials 1000, 0100, 0010, 0001, all `lesser` -> `result`=0000, `done` at edge 5, `error`=0. A=15 -> trials 1000, 1100, 1110, 1111 (`equal`) -> `result`=1111 at edge 5.
- Sweep A=0..15 back-to-back with `start` asserted every IDLE cycle -> `result`==A every conversion, `error`=0, `busy` never high with `done`.
- Force `greater` and `lesser` both high in TEST; separately force all three low -> `done` next cycle, `error`=1, `result`=`trial` at that point. The next `start` clears `error`.
- Hold `start` high continuously for A=5 -> conversions restart only from IDLE, never from TEST or DONE. Every `result`=0101.
- Assert `rst` during the second TEST cycle (A=11) -> all outputs 0 asynchronously, no `done`. After release, `start` gives `result`=1011.

Source files
------------

// File: rtl/sar_if.sv
// sar_if: handshake and comparator bus between the SAR search controller
// and its environment (requester plus 4-bit magnitude comparator).
//   start             requester -> controller  conversion request
//   greater/lesser/equal  comparator -> controller  A vs trial outcome
//   trial             controller -> comparator B operand
//   result/busy/done/error  controller -> requester  conversion status
// Modport master is the controller side, slave is the environment side.
interface sar_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             greater;
  logic             lesser;
  logic             equal;
  logic [WIDTH-1:0] trial;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
  logic             error;

  modport master (
    input  start, greater, lesser, equal,
    output trial, result, busy, done, error
  );

  modport slave (
    output start, greater, lesser, equal,
    input  trial, result, busy, done, error
  );
endinterface

// File: rtl/sar_controller.sv
// sar_controller: successive-approximation search controller. Drives a
// registered trial code to the comparator B operand and resolves the value
// on the comparator A operand one bit per cycle, MSB first, with early exit
// when the comparator reports equality.
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   sar_if.master: start in; greater/lesser/equal in;
//         trial/result/busy/done/error out (all registered)
module sar_controller #(
  parameter int WIDTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  sar_if.master bus
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MSB_CODE  = WIDTH'(1) << (WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_START = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TEST,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_trial;
  logic [WIDTH-1:0] r_result;
  logic [IDX_W-1:0] r_idx;
  logic             r_busy;
  logic             r_done;
  logic             r_error;

  logic [WIDTH-1:0] w_bit_cur;
  logic [WIDTH-1:0] w_bit_nxt;
  logic             w_onehot;
  logic             w_idx_zero;

  always_comb begin
    // One-hot masks for the bit under test and the next bit down.
    w_bit_cur  = WIDTH'(1) << r_idx;
    w_bit_nxt  = w_bit_cur >> 1;
    // Exactly one comparator flag high: odd parity rules out two-high,
    // the AND term rules out all-three-high.
    w_onehot   = (bus.greater ^ bus.lesser ^ bus.equal) &
                 ~(bus.greater & bus.lesser & bus.equal);
    w_idx_zero = (r_idx == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_trial  <= '0;
      r_result <= '0;
      r_idx    <= IDX_START;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_state <= S_TEST;
            r_trial <= MSB_CODE;
            r_idx   <= IDX_START;
            r_error <= 1'b0;
            r_busy  <= 1'b1;
          end
        end

        S_TEST: begin
          if (!w_onehot) begin
            // Inconsistent comparator: report the code under test as-is.
            r_error  <= 1'b1;
            r_result <= r_trial;
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else if (bus.equal) begin
            r_result <= r_trial;
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else if (bus.greater) begin
            if (w_idx_zero) begin
              // A above an all-bits-resolved trial cannot happen with a
              // consistent comparator.
              r_error  <= 1'b1;
              r_result <= r_trial;
              r_state  <= S_DONE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_trial <= r_trial | w_bit_nxt;
              r_idx   <= r_idx - 1'b1;
            end
          end else begin
            if (w_idx_zero) begin
              r_result <= r_trial & ~WIDTH'(1);
              r_state  <= S_DONE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_trial <= (r_trial & ~w_bit_cur) | w_bit_nxt;
              r_idx   <= r_idx - 1'b1;
            end
          end
        end

        S_DONE: begin
          // Single-cycle pulse; start is deliberately not looked at here.
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.trial  = r_trial;
  assign bus.result = r_result;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.error  = r_error;

endmodule
